// File: rtl/trigger_conditioner.sv
// trigger_conditioner: qualifies the external trigger pin, soft triggers and an
// internal periodic source into one-cycle strobes for the pulser core.
module trigger_conditioner #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_in,
    input  logic             soft_trig,
    input  logic             arm,
    input  logic             disarm,
    input  logic             busy_in,
    input  logic [1:0]       cfg_edge,
    input  logic [1:0]       cfg_mode,
    input  logic [15:0]      cfg_prescale,
    input  logic [CNT_W-1:0] cfg_holdoff,
    input  logic [CNT_W-1:0] cfg_period,
    output logic             trig_out,
    output logic             armed,
    output logic             holdoff_active,
    output logic [15:0]      missed_count
);

    localparam int unsigned VLD_W = SYNC_STAGES + 1;
    localparam int unsigned PRE_W = 16;

    localparam logic [1:0] MODE_CONT   = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_INT    = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_HOLDOFF = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [VLD_W-1:0]       vld_q;
    logic                   ext_evt_q;
    logic                   edge_c;
    logic [1:0]             mode_q;

    state_t                 state_q, state_d;
    logic [PRE_W-1:0]       pre_q, pre_d;
    logic [CNT_W-1:0]       hold_q, hold_d;
    logic [CNT_W-1:0]       per_q, per_d;
    logic                   trig_q, armed_q, hold_act_q;
    logic [15:0]            missed_q;

    logic                   fire_c;
    logic                   miss_c;
    logic                   mode_off_c;
    logic                   mode_chg_c;
    logic                   ext_ev_c;
    logic                   int_ev_c;
    logic                   soft_ev_c;
    logic                   run_per_c;
    logic [PRE_W-1:0]       pre_tgt_c;

    // Pin synchroniser, history flop and post-reset edge-suppression window
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            hist_q    <= 1'b0;
            vld_q     <= '0;
            ext_evt_q <= 1'b0;
            mode_q    <= MODE_CONT;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], trig_in};
            hist_q    <= sync_q[SYNC_STAGES-1];
            vld_q     <= {vld_q[VLD_W-2:0], 1'b1};
            ext_evt_q <= edge_c & vld_q[VLD_W-1];
            mode_q    <= cfg_mode;
        end
    end

    // Edge detector on the last sync stage versus history
    always_comb begin
        edge_c = 1'b0;
        case (cfg_edge)
            2'b00:   edge_c =  sync_q[SYNC_STAGES-1] & ~hist_q;
            2'b01:   edge_c = ~sync_q[SYNC_STAGES-1] &  hist_q;
            2'b10:   edge_c =  sync_q[SYNC_STAGES-1] ^  hist_q;
            default: edge_c = 1'b0;
        endcase
    end

    // Event qualification shared by the FSM and period counter
    always_comb begin
        mode_off_c = (cfg_mode == MODE_OFF);
        mode_chg_c = (cfg_mode != mode_q);
        ext_ev_c   = ext_evt_q & ((cfg_mode == MODE_CONT) | (cfg_mode == MODE_SINGLE));
        run_per_c  = ((state_q == S_ARMED) | (state_q == S_HOLDOFF)) & (cfg_mode == MODE_INT);
        int_ev_c   = run_per_c & (cfg_period != '0) & (per_q >= (cfg_period - CNT_W'(1)));
        soft_ev_c  = soft_trig & ~mode_off_c;
        pre_tgt_c  = (cfg_prescale == '0) ? '0 : (cfg_prescale - PRE_W'(1));
    end

    // Next-state, prescaler, holdoff and period counter logic
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        hold_d  = hold_q;
        per_d   = per_q;
        fire_c  = 1'b0;
        miss_c  = 1'b0;

        if (run_per_c) begin
            if ((cfg_period == '0) || int_ev_c) begin
                per_d = '0;
            end else begin
                per_d = per_q + CNT_W'(1);
            end
        end else begin
            per_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                hold_d = '0;
                if (arm && !mode_off_c) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (soft_ev_c || ext_ev_c || int_ev_c) begin
                    if (busy_in) begin
                        miss_c = 1'b1;
                    end else if (soft_ev_c) begin
                        // soft bypasses the prescaler and swallows a coincident ext/int event
                        fire_c = 1'b1;
                    end else if (pre_q >= pre_tgt_c) begin
                        fire_c = 1'b1;
                        pre_d  = '0;
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                if (fire_c) begin
                    hold_d = cfg_holdoff;
                    if (cfg_mode == MODE_SINGLE) begin
                        state_d = S_IDLE;
                    end else if (cfg_holdoff != '0) begin
                        state_d = S_HOLDOFF;
                    end
                end
            end
            S_HOLDOFF: begin
                if (soft_ev_c || ext_ev_c || int_ev_c) begin
                    miss_c = 1'b1;
                end
                if (hold_q <= CNT_W'(1)) begin
                    hold_d  = '0;
                    state_d = S_ARMED;
                end else begin
                    hold_d = hold_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (mode_chg_c) begin
            pre_d = '0;
            per_d = '0;
        end

        // disarm / mode off dominate everything, including arm and pending events
        if (disarm || mode_off_c) begin
            state_d = S_IDLE;
            pre_d   = '0;
            hold_d  = '0;
            per_d   = '0;
            fire_c  = 1'b0;
            miss_c  = 1'b0;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pre_q      <= '0;
            hold_q     <= '0;
            per_q      <= '0;
            trig_q     <= 1'b0;
            armed_q    <= 1'b0;
            hold_act_q <= 1'b0;
            missed_q   <= '0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            hold_q     <= hold_d;
            per_q      <= per_d;
            trig_q     <= fire_c;
            armed_q    <= (state_d == S_ARMED);
            hold_act_q <= (state_d == S_HOLDOFF);
            if (miss_c && (missed_q != 16'hFFFF)) begin
                missed_q <= missed_q + 16'd1;
            end
        end
    end

    assign trig_out       = trig_q;
    assign armed          = armed_q;
    assign holdoff_active = hold_act_q;
    assign missed_count   = missed_q;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed bench for trigger_conditioner with hand-computed expectations.
module tb_trigger_conditioner;

    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             trig_in;
    logic             soft_trig;
    logic             arm;
    logic             disarm;
    logic             busy_in;
    logic [1:0]       cfg_edge;
    logic [1:0]       cfg_mode;
    logic [15:0]      cfg_prescale;
    logic [CNT_W-1:0] cfg_holdoff;
    logic [CNT_W-1:0] cfg_period;
    logic             trig_out;
    logic             armed;
    logic             holdoff_active;
    logic [15:0]      missed_count;

    int errors = 0;
    int checks = 0;

    trigger_conditioner #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .trig_in        (trig_in),
        .soft_trig      (soft_trig),
        .arm            (arm),
        .disarm         (disarm),
        .busy_in        (busy_in),
        .cfg_edge       (cfg_edge),
        .cfg_mode       (cfg_mode),
        .cfg_prescale   (cfg_prescale),
        .cfg_holdoff    (cfg_holdoff),
        .cfg_period     (cfg_period),
        .trig_out       (trig_out),
        .armed          (armed),
        .holdoff_active (holdoff_active),
        .missed_count   (missed_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the pin to a level; a qualified edge shows on trig_out 4 samples later
    task automatic pin_to(input logic level, input logic exp_fire, input string tag);
        trig_in = level;
        step(); chk({tag, "_lat0"}, trig_out, 1'b0);
        step(); chk({tag, "_lat1"}, trig_out, 1'b0);
        step(); chk({tag, "_lat2"}, trig_out, 1'b0);
        step(); chk({tag, "_fire"}, trig_out, exp_fire);
        step(); chk({tag, "_width"}, trig_out, 1'b0);
        repeat (5) step();
    endtask

    task automatic pulse_arm();
        arm = 1'b1; step(); arm = 1'b0;
    endtask

    task automatic pulse_disarm();
        disarm = 1'b1; step(); disarm = 1'b0;
    endtask

    int n_fire;
    int fire_at [8];
    int n_hold;
    int hold_first;

    initial begin
        rst = 1'b1; trig_in = 1'b0; soft_trig = 1'b0; arm = 1'b0; disarm = 1'b0;
        busy_in = 1'b0; cfg_edge = 2'b00; cfg_mode = 2'b00; cfg_prescale = 16'd0;
        cfg_holdoff = '0; cfg_period = '0;

        // Reset state
        repeat (3) step();
        chk("rst_trig", trig_out, 1'b0);
        chk("rst_armed", armed, 1'b0);
        chk("rst_hold", holdoff_active, 1'b0);
        chk("rst_missed", missed_count, 16'd0);
        rst = 1'b0;
        repeat (5) step();

        // Basic rising edges, prescale 0, holdoff 0
        pulse_arm();
        chk("t1_armed", armed, 1'b1);
        for (int e = 0; e < 3; e++) begin
            pin_to(1'b1, 1'b1, "t1_rise");
            pin_to(1'b0, 1'b0, "t1_fall");
            repeat (80) step();
        end
        chk("t1_missed", missed_count, 16'd0);
        soft_trig = 1'b1; step(); soft_trig = 1'b0;
        chk("t1_soft", trig_out, 1'b1);
        step();
        chk("t1_soft_width", trig_out, 1'b0);

        // Prescale 4: fires on 4th and 8th edge; disarm clears the prescaler
        cfg_prescale = 16'd4;
        for (int e = 1; e <= 10; e++) begin
            pin_to(1'b1, ((e % 4) == 0) ? 1'b1 : 1'b0, "t2_rise");
            pin_to(1'b0, 1'b0, "t2_fall");
        end
        pulse_disarm();
        chk("t2_disarmed", armed, 1'b0);
        pulse_arm();
        chk("t2_rearmed", armed, 1'b1);
        for (int e = 0; e < 2; e++) begin
            pin_to(1'b1, 1'b0, "t2_cleared");
            pin_to(1'b0, 1'b0, "t2_fall2");
        end

        // Holdoff 50: edges sampled at 0, 20, 60 -> fires at 3 and 63, one miss
        cfg_prescale = 16'd0;
        cfg_holdoff  = 32'd50;
        pulse_disarm();
        pulse_arm();
        repeat (5) step();
        n_fire = 0; n_hold = 0; hold_first = -1;
        for (int i = 0; i < 100; i++) begin
            trig_in = (i < 10) || (i >= 20 && i < 30) || (i >= 60);
            step();
            if (trig_out) begin
                if (n_fire < 8) fire_at[n_fire] = i;
                n_fire++;
            end
            if (holdoff_active && i < 60) begin
                if (hold_first < 0) hold_first = i;
                n_hold++;
            end
        end
        chk("t3_nfire", n_fire, 2);
        chk("t3_fire0", fire_at[0], 3);
        chk("t3_fire1", fire_at[1], 63);
        chk("t3_hold_len", n_hold, 50);
        chk("t3_hold_first", hold_first, 3);
        chk("t3_missed", missed_count, 16'd1);
        trig_in = 1'b0;
        repeat (60) step();

        // Single-shot, both edges
        pulse_disarm();
        cfg_mode = 2'b01; cfg_edge = 2'b10; cfg_holdoff = '0;
        repeat (3) step();
        pulse_arm();
        chk("t4_armed", armed, 1'b1);
        pin_to(1'b1, 1'b1, "t4_first");
        chk("t4_dropped", armed, 1'b0);
        pin_to(1'b0, 1'b0, "t4_ignored");
        chk("t4_missed", missed_count, 16'd1);
        pulse_arm();
        chk("t4_rearmed", armed, 1'b1);
        pin_to(1'b1, 1'b1, "t4_again");
        chk("t4_dropped2", armed, 1'b0);

        // Internal periodic source, period 100, busy across wrap 3, soft on wrap 5
        pulse_disarm();
        cfg_mode = 2'b10; cfg_edge = 2'b00; cfg_period = 32'd100;
        cfg_holdoff = '0; cfg_prescale = 16'd0;
        repeat (3) step();
        pulse_arm();
        n_fire = 0;
        for (int i = 1; i <= 505; i++) begin
            busy_in   = (i >= 296 && i <= 305);
            soft_trig = (i == 500);
            step();
            if (trig_out) begin
                if (n_fire < 8) fire_at[n_fire] = i;
                n_fire++;
            end
        end
        busy_in = 1'b0; soft_trig = 1'b0;
        chk("t5_nfire", n_fire, 4);
        chk("t5_wrap1", fire_at[0], 100);
        chk("t5_wrap2", fire_at[1], 200);
        chk("t5_wrap4", fire_at[2], 400);
        chk("t5_wrap5_soft", fire_at[3], 500);
        chk("t5_missed", missed_count, 16'd2);
        pulse_disarm();

        // Pin held high through reset must not produce an edge
        cfg_mode = 2'b00; cfg_edge = 2'b00; cfg_period = '0;
        trig_in = 1'b1; rst = 1'b1;
        repeat (3) step();
        chk("t6_rst_trig", trig_out, 1'b0);
        chk("t6_rst_armed", armed, 1'b0);
        chk("t6_rst_missed", missed_count, 16'd0);
        rst = 1'b0;
        pulse_arm();
        chk("t6_armed", armed, 1'b1);
        n_fire = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (trig_out) n_fire++;
        end
        chk("t6_nfire", n_fire, 0);
        chk("t6_missed", missed_count, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
